async_receiver_cfg: RTL and testbench
=====================================

ASYNC_RECEIVER_CFG -- requirements
Module: async_receiver_cfg

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..9.
REQ-002 Parameter OVERSAMPLE_WIDTH, default 3, meaning log2 of clk_uart cycles per bit, legal range 2..5; OVERSAMPLE_RATE = 1 << OVERSAMPLE_WIDTH.
REQ-003 Parameter PARITY, default PAR_NONE, meaning parity mode PAR_NONE, PAR_EVEN or PAR_ODD.
REQ-004 Parameter STOP_BITS, default 1, meaning stop bits checked, 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4, meaning receive buffer entries, power of two, 2..16.
REQ-006 Port clk_uart, input, 1, meaning receive clock at OVERSAMPLE_RATE x baud.
REQ-007 Port rst, input, 1, meaning synchronous, active-high reset.
REQ-008 Port rx, input, 1, meaning asynchronous serial line, idle high.
REQ-009 Port m_data, output, DATA_BITS, meaning head-of-buffer data, LSB first on the wire.
REQ-010 Port m_frame_err, output, 1, meaning head word had a low stop bit.
REQ-011 Port m_parity_err, output, 1, meaning head word failed parity; always 0 when PARITY is PAR_NONE.
REQ-012 Port m_valid, output, 1, meaning buffer non-empty.
REQ-013 Port m_ready, input, 1, meaning consumer accepts head word.
REQ-014 Port overrun, output, 1, meaning sticky flag, set when a completed word is dropped because the buffer is full.
REQ-015 Port clr_err, input, 1, meaning clears overrun.
REQ-016 Port busy, output, 1, meaning receiver is not in IDLE.

Function
REQ-017 rx SHALL pass through the team synchronizer (INITIAL_VALUE 1) and then spike_filter (INITIAL_VALUE 1); all sampling SHALL use the filtered signal, rxf.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-019 A single OVERSAMPLE_WIDTH-bit phase counter SHALL be held at 0 in IDLE and increment each cycle otherwise; a sample strobe SHALL fire when the counter equals OVERSAMPLE_RATE/2-1, which is mid-bit.
REQ-020 In IDLE, rxf=0 SHALL move the FSM to START.
REQ-021 At the START strobe, rxf=1 (false start) SHALL return the FSM to IDLE with nothing pushed; otherwise the FSM SHALL move to DATA.
REQ-022 In DATA, each strobe SHALL shift rxf into the MSB of a DATA_BITS shift register; after DATA_BITS strobes the FSM SHALL go to PARITY if PARITY is not PAR_NONE, else to STOP.
REQ-023 At the PARITY strobe, parity_err SHALL be set to (XOR of data bits XOR rxf) != 0 for PAR_EVEN, and == 0 for PAR_ODD.
REQ-024 In STOP, each of STOP_BITS strobes SHALL check rxf; any 0 SHALL set frame_err.
REQ-025 The word {data, frame_err, parity_err} SHALL be pushed on the final stop strobe, regardless of error flags.
REQ-026 After the final stop strobe the FSM SHALL go to IDLE if rxf=1, else to WAIT_IDLE.
REQ-027 WAIT_IDLE SHALL hold until rxf=1 and then go to IDLE, so a break produces exactly one word.
REQ-028 The buffer SHALL be first-word-fall-through; m_* SHALL be valid in the cycle after the push.
REQ-029 A pop SHALL occur when m_valid && m_ready; m_data is undefined while m_valid=0.
REQ-030 Push when full without pop SHALL drop the word and set overrun; push and pop when full in the same cycle SHALL accept both.
REQ-031 Push and pop when empty in the same cycle: the push SHALL succeed, and m_valid SHALL assert next cycle.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL use a log2(FIFO_DEPTH)+1-bit count.
REQ-033 When clr_err and an overrun-setting event occur in the same cycle, overrun SHALL end that cycle set.

Reset
REQ-034 rst SHALL set the FSM to IDLE, the phase counter, pointers, count and shift register to 0, m_valid, overrun and busy to 0, and the synchronizer/filter outputs to 1.
REQ-035 rst mid-frame SHALL discard the partial word with no push; the first subsequent falling edge SHALL start a fresh frame.

Structure
REQ-036 Package uart_pkg SHALL hold the parity_t enum (PAR_NONE, PAR_EVEN, PAR_ODD) and the rx_state_t enum.
REQ-037 The buffer SHALL be a sub-module uart_rx_fifo, parameterised by width (DATA_BITS+2) and FIFO_DEPTH.

Verification
REQ-038 8N1, 8x, frame 0x55 then 0xA3 -> two words 0x55 and 0xA3 in order, both error flags 0, overrun 0.
REQ-039 PARITY=PAR_EVEN, byte 0x07 sent with parity bit 1 -> m_parity_err=0; same byte with parity 0 -> m_parity_err=1.
REQ-040 A 2-cycle low glitch on idle line, then a 3-cycle low pulse -> no push, busy returns to 0, m_valid stays 0.
REQ-041 Break: rx low for 20 bit times -> exactly one word, data 0x00 and m_frame_err=1; a following valid 0x3C frame is received cleanly.
REQ-042 FIFO_DEPTH=4, m_ready=0, 5 frames -> first 4 retained, overrun=1; clr_err -> overrun=0; m_ready held with a 6th frame arriving -> no loss.
REQ-043 rst asserted during data bit 4 of a frame -> no word pushed; the next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types for the UART receive path: parity mode selector
//            and receiver FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/spike_filter.sv
`default_nettype none
// ============================================================================
// Module   : spike_filter
// Purpose  : Rejects single-cycle spikes: the output only follows the input
//            once the input has held the same value for two samples.
// Ports    : clk, rst  - clock and synchronous active-high reset
//            i_d       - synchronized input
//            o_q       - filtered output (INITIAL_VALUE during reset)
// Revision : 1.0 - initial release
// ============================================================================
module spike_filter #(
    parameter logic INITIAL_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_prev;
    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= INITIAL_VALUE;
            r_q    <= INITIAL_VALUE;
        end else begin
            r_prev <= i_d;
            if (i_d == r_prev) begin
                r_q <= i_d;
            end
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/synchronizer.sv
`default_nettype none
// ============================================================================
// Module   : synchronizer
// Purpose  : Two-flop synchronizer for a single asynchronous bit.
// Ports    : clk, rst  - clock and synchronous active-high reset
//            i_d       - asynchronous input
//            o_q       - synchronized output (INITIAL_VALUE during reset)
// Revision : 1.0 - initial release
// ============================================================================
module synchronizer #(
    parameter logic INITIAL_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= INITIAL_VALUE;
            r_sync <= INITIAL_VALUE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : First-word-fall-through receive buffer. A push when full is
//            dropped (flagged on o_drop) unless a pop frees a slot in the
//            same cycle.
// Ports    : clk, rst  - clock and synchronous active-high reset
//            i_push    - write request, i_data - word to write
//            i_pop     - consumer accepts head word (ignored when empty)
//            o_data    - head word, o_valid - buffer non-empty
//            o_drop    - pushed word discarded this cycle
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_drop
);

    localparam int            c_AW         = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL_COUNT = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_full;
    logic             w_pop;
    logic             w_wr;

    assign w_full  = (r_count == c_FULL_COUNT);
    assign o_valid = (r_count != '0);
    assign w_pop   = i_pop && o_valid;
    // A same-cycle pop frees the slot the push needs.
    assign w_wr    = i_push && (!w_full || w_pop);
    assign o_drop  = i_push && w_full && !w_pop;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/async_receiver_cfg.sv
`default_nettype none
// ============================================================================
// Module   : async_receiver_cfg
// Purpose  : Configurable oversampling UART receiver with FWFT buffer.
// Ports    : clk_uart     - receive clock, OVERSAMPLE_RATE x baud
//            rst          - synchronous active-high reset
//            rx           - asynchronous serial line, idle high
//            m_data       - head-of-buffer data (LSB first on the wire)
//            m_frame_err  - head word saw a low stop bit
//            m_parity_err - head word failed parity
//            m_valid      - buffer non-empty, m_ready - consumer accepts head
//            overrun      - sticky: a completed word was dropped (buffer full)
//            clr_err      - clears overrun
//            busy         - receiver is mid-frame (not IDLE)
// Revision : 1.0 - initial release
// ============================================================================
module async_receiver_cfg
    import uart_pkg::*;
#(
    parameter int      DATA_BITS        = 8,
    parameter int      OVERSAMPLE_WIDTH = 3,
    parameter parity_t PARITY           = PAR_NONE,
    parameter int      STOP_BITS        = 1,
    parameter int      FIFO_DEPTH       = 4
) (
    input  logic                 clk_uart,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_frame_err,
    output logic                 m_parity_err,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun,
    input  logic                 clr_err,
    output logic                 busy
);

    localparam int                          c_OVERSAMPLE_RATE = 1 << OVERSAMPLE_WIDTH;
    localparam logic [OVERSAMPLE_WIDTH-1:0] c_MID_PHASE = OVERSAMPLE_WIDTH'(c_OVERSAMPLE_RATE / 2 - 1);
    localparam logic [3:0]                  c_LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]                  c_LAST_STOP = 4'(STOP_BITS - 1);
    localparam int                          c_WORD_W    = DATA_BITS + 2;

    logic                        w_rx_sync;
    logic                        w_rxf;
    rx_state_t                   r_state;
    rx_state_t                   w_state_nxt;
    logic [OVERSAMPLE_WIDTH-1:0] r_phase;
    logic [3:0]                  r_bit_cnt;
    logic [DATA_BITS-1:0]        r_shift;
    logic                        r_frame_err;
    logic                        r_parity_err;
    logic                        r_overrun;
    logic                        w_strobe;
    logic                        w_push;
    logic                        w_drop;
    logic                        w_par_sum;
    logic [c_WORD_W-1:0]         w_push_word;
    logic [c_WORD_W-1:0]         w_head_word;

    synchronizer #(.INITIAL_VALUE(1'b1)) u_sync (
        .clk (clk_uart),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_sync)
    );

    spike_filter #(.INITIAL_VALUE(1'b1)) u_filter (
        .clk (clk_uart),
        .rst (rst),
        .i_d (w_rx_sync),
        .o_q (w_rxf)
    );

    // The phase counter is zero on entry to START, so the strobe lands
    // mid-bit for the start bit and every bit after it.
    assign w_strobe    = (r_phase == c_MID_PHASE);
    assign w_par_sum   = (^r_shift) ^ w_rxf;
    // The final stop sample is folded in directly so the pushed word
    // carries it without waiting a cycle.
    assign w_push_word = {r_shift, r_frame_err | ~w_rxf, r_parity_err};

    always_ff @(posedge clk_uart) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_rxf) w_state_nxt = ST_START;
            end
            ST_START: begin
                if (w_strobe) w_state_nxt = w_rxf ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_strobe && (r_bit_cnt == c_LAST_DATA)) begin
                    w_state_nxt = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (w_strobe) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (w_strobe && (r_bit_cnt == c_LAST_STOP)) begin
                    w_push      = 1'b1;
                    // A line still low here is a break; hold until it releases.
                    w_state_nxt = w_rxf ? ST_IDLE : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (w_rxf) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_uart) begin
        if (rst) begin
            r_phase      <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) || (w_state_nxt == ST_IDLE)) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + 1'b1;
            end
            if (w_strobe) begin
                case (r_state)
                    ST_START: begin
                        r_bit_cnt    <= '0;
                        r_frame_err  <= 1'b0;
                        r_parity_err <= 1'b0;
                    end
                    ST_DATA: begin
                        r_shift   <= {w_rxf, r_shift[DATA_BITS-1:1]};
                        // Counter is reused for stop bits, so restart it here.
                        r_bit_cnt <= (r_bit_cnt == c_LAST_DATA) ? '0 : r_bit_cnt + 1'b1;
                    end
                    ST_PARITY: begin
                        r_parity_err <= (PARITY == PAR_ODD) ? ~w_par_sum : w_par_sum;
                    end
                    ST_STOP: begin
                        if (!w_rxf) r_frame_err <= 1'b1;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Setting wins over clearing so a drop coinciding with clr_err is kept.
    always_ff @(posedge clk_uart) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clr_err) begin
            r_overrun <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .WIDTH (c_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_uart),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_word),
        .i_pop   (m_ready),
        .o_data  (w_head_word),
        .o_valid (m_valid),
        .o_drop  (w_drop)
    );

    assign {m_data, m_frame_err, m_parity_err} = w_head_word;
    assign overrun = r_overrun;
    assign busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_async_receiver_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_async_receiver_cfg
// Purpose  : Self-checking bench for async_receiver_cfg. Two instances:
//            dut_a (8N1) and dut_b (8 data, even parity, 2 stop bits).
//            Frames are generated bit by bit; the expected word is queued
//            when a frame starts and a monitor compares every handshake.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_async_receiver_cfg;
    import uart_pkg::*;

    localparam int c_DATA_BITS = 8;
    localparam int c_OSR       = 8;
    localparam int c_DEPTH     = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       frame_err;
        logic       parity_err;
    } word_t;

    logic       clk_uart = 1'b0;
    logic       rst      = 1'b1;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       m_ready_a = 1'b1, m_ready_b = 1'b1;
    logic       clr_err_a = 1'b0, clr_err_b = 1'b0;
    logic [7:0] m_data_a, m_data_b;
    logic       m_frame_err_a, m_frame_err_b;
    logic       m_parity_err_a, m_parity_err_b;
    logic       m_valid_a, m_valid_b;
    logic       overrun_a, overrun_b;
    logic       busy_a, busy_b;

    word_t      sb_a[$];
    word_t      sb_b[$];
    logic       exp_ovr_a = 1'b0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] d;
    logic       p, s1, s2;

    always #5 clk_uart = ~clk_uart;

    async_receiver_cfg #(
        .DATA_BITS(8), .OVERSAMPLE_WIDTH(3), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(c_DEPTH)
    ) dut_a (
        .clk_uart(clk_uart), .rst(rst), .rx(rx_a),
        .m_data(m_data_a), .m_frame_err(m_frame_err_a), .m_parity_err(m_parity_err_a),
        .m_valid(m_valid_a), .m_ready(m_ready_a), .overrun(overrun_a),
        .clr_err(clr_err_a), .busy(busy_a)
    );

    async_receiver_cfg #(
        .DATA_BITS(8), .OVERSAMPLE_WIDTH(3), .PARITY(PAR_EVEN), .STOP_BITS(2), .FIFO_DEPTH(c_DEPTH)
    ) dut_b (
        .clk_uart(clk_uart), .rst(rst), .rx(rx_b),
        .m_data(m_data_b), .m_frame_err(m_frame_err_b), .m_parity_err(m_parity_err_b),
        .m_valid(m_valid_b), .m_ready(m_ready_b), .overrun(overrun_b),
        .clr_err(clr_err_b), .busy(busy_b)
    );

    task automatic tick();
        @(posedge clk_uart);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic bit_a(input logic v);
        rx_a = v;
        repeat (c_OSR) tick();
    endtask

    task automatic bit_b(input logic v);
        rx_b = v;
        repeat (c_OSR) tick();
    endtask

    // 8N1 frame followed by one idle bit. A word is expected unless the
    // consumer is stalled and the buffer already holds DEPTH words.
    task automatic send_a(input logic [7:0] data, input logic stop);
        word_t w;
        w.data       = data;
        w.frame_err  = ~stop;
        w.parity_err = 1'b0;
        if (!m_ready_a && (sb_a.size() >= c_DEPTH)) exp_ovr_a = 1'b1;
        else sb_a.push_back(w);
        bit_a(1'b0);
        for (int i = 0; i < c_DATA_BITS; i++) bit_a(data[i]);
        bit_a(stop);
        bit_a(1'b1);
    endtask

    // 8E2 frame with an explicit parity bit; even parity holds when the
    // total count of ones over data and parity bit is even.
    task automatic send_b(input logic [7:0] data, input logic pbit, input logic st1, input logic st2);
        word_t w;
        w.data       = data;
        w.frame_err  = !(st1 && st2);
        w.parity_err = (($countones({data, pbit}) % 2) != 0);
        sb_b.push_back(w);
        bit_b(1'b0);
        for (int i = 0; i < c_DATA_BITS; i++) bit_b(data[i]);
        bit_b(pbit);
        bit_b(st1);
        bit_b(st2);
        bit_b(1'b1);
    endtask

    task automatic monitor();
        word_t e;
        forever begin
            @(negedge clk_uart);
            if (!rst && m_valid_a && m_ready_a) begin
                if (sb_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_word: actual data 0x%0h required no word", m_data_a);
                end else begin
                    e = sb_a.pop_front();
                    check("a_data", 32'(m_data_a), 32'(e.data));
                    check("a_frame_err", 32'(m_frame_err_a), 32'(e.frame_err));
                    check("a_parity_err", 32'(m_parity_err_a), 32'(e.parity_err));
                end
            end
            if (!rst && m_valid_b && m_ready_b) begin
                if (sb_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_word: actual data 0x%0h required no word", m_data_b);
                end else begin
                    e = sb_b.pop_front();
                    check("b_data", 32'(m_data_b), 32'(e.data));
                    check("b_frame_err", 32'(m_frame_err_b), 32'(e.frame_err));
                    check("b_parity_err", 32'(m_parity_err_b), 32'(e.parity_err));
                end
            end
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (((sb_a.size() != 0) || (sb_b.size() != 0)) && (n < 4000)) begin
            tick();
            n++;
        end
        checks++;
        if ((sb_a.size() != 0) || (sb_b.size() != 0)) begin
            errors++;
            $display("FAIL %s: actual %0d/%0d words outstanding required 0", name, sb_a.size(), sb_b.size());
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        repeat (5) tick();
        rst = 1'b0;
        tick();
        check("reset_m_valid_a", 32'(m_valid_a), 32'd0);
        check("reset_m_valid_b", 32'(m_valid_b), 32'd0);
        check("reset_overrun_a", 32'(overrun_a), 32'd0);
        check("reset_overrun_b", 32'(overrun_b), 32'd0);
        check("reset_busy_a", 32'(busy_a), 32'd0);
        check("reset_busy_b", 32'(busy_b), 32'd0);

        // Two clean 8N1 frames.
        send_a(8'h55, 1'b1);
        send_a(8'hA3, 1'b1);
        drain("drain_basic");
        check("basic_overrun_a", 32'(overrun_a), 32'(exp_ovr_a));

        // Even parity: correct and wrong parity bit for 0x07.
        send_b(8'h07, 1'b1, 1'b1, 1'b1);
        send_b(8'h07, 1'b0, 1'b1, 1'b1);
        repeat (12) begin
            d  = 8'($urandom);
            p  = 1'($urandom_range(0, 1));
            s1 = ($urandom_range(0, 4) != 0);
            s2 = ($urandom_range(0, 4) != 0);
            send_b(d, p, s1, s2);
        end
        drain("drain_parity");

        // Glitches on an idle line must not produce a word.
        rx_a = 1'b0;
        repeat (2) tick();
        rx_a = 1'b1;
        repeat (20) tick();
        rx_a = 1'b0;
        repeat (3) tick();
        rx_a = 1'b1;
        repeat (3 * c_OSR) tick();
        check("glitch_busy_a", 32'(busy_a), 32'd0);
        check("glitch_m_valid_a", 32'(m_valid_a), 32'd0);

        // Break: 20 bit times low yields a single all-zero framing error word.
        sb_a.push_back(word_t'{data: 8'h00, frame_err: 1'b1, parity_err: 1'b0});
        rx_a = 1'b0;
        repeat (20 * c_OSR) tick();
        rx_a = 1'b1;
        repeat (2 * c_OSR) tick();
        send_a(8'h3C, 1'b1);
        drain("drain_break");

        // Backpressure: five frames into a four-deep buffer.
        m_ready_a = 1'b0;
        repeat (5) send_a(8'($urandom), 1'b1);
        repeat (2 * c_OSR) tick();
        check("ovr_overrun_a", 32'(overrun_a), 32'(exp_ovr_a));
        check("ovr_m_valid_a", 32'(m_valid_a), 32'd1);
        clr_err_a = 1'b1;
        tick();
        clr_err_a = 1'b0;
        exp_ovr_a = 1'b0;
        check("ovr_cleared_a", 32'(overrun_a), 32'd0);
        m_ready_a = 1'b1;
        send_a(8'($urandom), 1'b1);
        drain("drain_overrun");

        // Random frames with per-frame consumer stalls and stop errors.
        repeat (16) begin
            m_ready_a = ($urandom_range(0, 2) != 0);
            send_a(8'($urandom), ($urandom_range(0, 4) != 0));
        end
        m_ready_a = 1'b1;
        drain("drain_random");
        check("random_overrun_a", 32'(overrun_a), 32'(exp_ovr_a));
        clr_err_a = 1'b1;
        tick();
        clr_err_a = 1'b0;
        exp_ovr_a = 1'b0;

        // Reset during data bit 4 of 0x81 discards the partial frame.
        d = 8'h81;
        bit_a(1'b0);
        for (int i = 0; i < 4; i++) bit_a(d[i]);
        rx_a = d[4];
        repeat (4) tick();
        rst  = 1'b1;
        rx_a = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("midrst_busy_a", 32'(busy_a), 32'd0);
        check("midrst_m_valid_a", 32'(m_valid_a), 32'd0);
        check("midrst_overrun_a", 32'(overrun_a), 32'd0);
        repeat (2 * c_OSR) tick();
        send_a(8'h81, 1'b1);
        drain("drain_after_reset");
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual time limit reached required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
